// File: rtl/pause_arbiter.sv
// rtl/pause_arbiter.sv - user/OSD pause merge and high-score RAM arbiter; dimming under PAUSE_ARBITER_DIM_EN
module pause_arbiter #(
  parameter logic [31:0] DIM_CYCLES    = 32'h0ABA9500,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic user_pause,
  input  logic osd_open,
  input  logic osd_pause_en,
  input  logic hs_req,
  output logic hs_grant,
  output logic pause,
  output logic user_paused,
  output logic dim_video
);

  typedef enum logic [1:0] {IDLE, HALT, GRANT, RELEASE} state_t;

  state_t     state, state_next;
  logic [3:0] settle_cnt, settle_next;
  logic       user_pause_q;
  logic       user_pause_armed;
  logic       user_paused_next;

  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    case (state)
      IDLE: begin
        if (hs_req) begin
          state_next  = HALT;
          settle_next = 4'(SETTLE_CYCLES);
        end
      end
      HALT: begin
        if (!hs_req) begin
          state_next = IDLE;
        end else if (settle_cnt == 4'd0) begin
          state_next = GRANT;
        end else begin
          settle_next = settle_cnt - 4'd1;
        end
      end
      GRANT: begin
        if (!hs_req) begin
          state_next = RELEASE;
        end
      end
      RELEASE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A button held through reset is ignored until it has been seen released once.
  assign user_paused_next = user_paused ^ (user_pause & ~user_pause_q & user_pause_armed);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      settle_cnt       <= 4'd0;
      user_pause_q     <= 1'b0;
      user_pause_armed <= 1'b0;
      user_paused      <= 1'b0;
      pause            <= 1'b0;
      hs_grant         <= 1'b0;
    end else begin
      state            <= state_next;
      settle_cnt       <= settle_next;
      user_pause_q     <= user_pause;
      user_pause_armed <= user_pause_armed | ~user_pause;
      user_paused      <= user_paused_next;
      pause            <= user_paused_next | (osd_open & osd_pause_en) | (state_next != IDLE);
      hs_grant         <= (state_next == GRANT);
    end
  end

`ifdef PAUSE_ARBITER_DIM_EN
  logic [31:0] dim_cnt;

  // Only a user pause ages the screen; OSD and high-score halts leave it alone.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dim_cnt <= 32'd0;
    end else if (!user_paused) begin
      dim_cnt <= 32'd0;
    end else if (dim_cnt < DIM_CYCLES) begin
      dim_cnt <= dim_cnt + 32'd1;
    end
  end

  assign dim_video = user_paused && (dim_cnt >= DIM_CYCLES);
`else
  logic unused_dim_cfg;
  assign unused_dim_cfg = ^DIM_CYCLES;
  assign dim_video      = 1'b0;
`endif

endmodule

// File: tb/tb_pause_arbiter.sv
// tb/tb_pause_arbiter.sv - randomized and directed bench for pause_arbiter against a behavioural model
module tb_pause_arbiter;

  localparam int SETTLE = 4;
  localparam int DIM    = 16;
`ifdef PAUSE_ARBITER_DIM_EN
  localparam bit DIM_ON = 1'b1;
`else
  localparam bit DIM_ON = 1'b0;
`endif

  logic clk_sys = 1'b0;
  logic reset, user_pause, osd_open, osd_pause_en, hs_req;
  logic hs_grant, pause, user_paused, dim_video;

  int checks   = 0;
  int failures = 0;

  // Model: m_run counts consecutive sampled hs_req cycles since leaving idle.
  int m_run;
  bit m_rel, m_up, m_prev, m_armed, m_pause;
  int m_dim;

  always #5 clk_sys = ~clk_sys;

  pause_arbiter #(
    .DIM_CYCLES   (32'd16),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .user_pause  (user_pause),
    .osd_open    (osd_open),
    .osd_pause_en(osd_pause_en),
    .hs_req      (hs_req),
    .hs_grant    (hs_grant),
    .pause       (pause),
    .user_paused (user_paused),
    .dim_video   (dim_video)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_up = 0; m_prev = 0; m_armed = 0; m_pause = 0; m_dim = 0;
  endtask

  task automatic model_step();
    bit toggle;
    if (!m_up) m_dim = 0;
    else if (m_dim < DIM) m_dim++;
    toggle = user_pause && !m_prev && m_armed;
    if (!user_pause) m_armed = 1;
    m_prev = user_pause;
    if (toggle) m_up = !m_up;
    if (m_rel) begin
      m_rel = 0;
      m_run = 0;
    end else if (m_run == 0) begin
      if (hs_req) m_run = 1;
    end else if (hs_req) begin
      if (m_run < 1000) m_run++;
    end else begin
      m_rel = (m_run >= SETTLE + 2);
      m_run = 0;
    end
    m_pause = m_up || (osd_open && osd_pause_en) || (m_run > 0) || m_rel;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "/pause"}, pause, m_pause);
    check_val({tag, "/grant"}, hs_grant, (m_run >= SETTLE + 2));
    check_val({tag, "/user_paused"}, user_paused, m_up);
    check_val({tag, "/dim"}, dim_video, DIM_ON && m_up && (m_dim >= DIM));
    check_val({tag, "/grant_wo_pause"}, hs_grant & ~pause, 0);
`ifdef PAUSE_ARBITER_DIM_EN
    check_val({tag, "/dim_cnt"}, dut.dim_cnt, m_dim);
`endif
  endtask

  task automatic tick(input string tag);
    @(posedge clk_sys);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    int toggles;
    int waited;
    logic last_up;
    reset = 1'b0; user_pause = 1'b0; osd_open = 1'b0; osd_pause_en = 1'b0; hs_req = 1'b0;
    #2;
    apply_reset();

    // Request from idle: pause at cycle 1, grant at cycle 6, release sequence.
    hs_req = 1'b1;
    tick("req_c1");
    check_val("req_pause_c1", pause, 1);
    check_val("req_grant_c1", hs_grant, 0);
    for (int c = 2; c <= 5; c++) begin
      tick("req_settle");
      check_val("req_grant_early", hs_grant, 0);
    end
    tick("req_c6");
    check_val("req_grant_c6", hs_grant, 1);
    repeat (3) tick("req_hold");
    hs_req = 1'b0;
    tick("rel_c1");
    check_val("rel_grant", hs_grant, 0);
    check_val("rel_pause_held", pause, 1);
    tick("rel_c2");
    check_val("rel_pause_drop", pause, 0);

    // Request dropped during settling.
    hs_req = 1'b1;
    repeat (2) tick("short_req");
    hs_req = 1'b0;
    tick("short_drop1");
    tick("short_drop2");
    check_val("short_pause", pause, 0);
    check_val("short_grant", hs_grant, 0);

    // Re-request during RELEASE is serviced only after idle.
    hs_req = 1'b1;
    repeat (7) tick("rereq_grant");
    hs_req = 1'b0;
    tick("rereq_release");
    hs_req = 1'b1;
    waited = 0;
    while (!hs_grant && waited < 20) begin
      tick("rereq_wait");
      waited++;
    end
    check_val("rereq_latency", waited, SETTLE + 3);
    hs_req = 1'b0;
    repeat (3) tick("rereq_end");

    // User toggle during HALT and GRANT keeps pause and grant.
    hs_req = 1'b1;
    repeat (2) tick("mix_halt");
    user_pause = 1'b1;
    tick("mix_press");
    check_val("mix_up_on", user_paused, 1);
    user_pause = 1'b0;
    repeat (6) tick("mix_to_grant");
    user_pause = 1'b1;
    tick("mix_unpress");
    check_val("mix_grant_kept", hs_grant, 1);
    check_val("mix_pause_kept", pause, 1);
    user_pause = 1'b0;
    osd_open = 1'b1;
    tick("mix_osd");
    osd_open = 1'b0;
    hs_req = 1'b0;
    repeat (3) tick("mix_end");

    // Held button toggles once; dim saturates; second press unpauses.
    user_pause = 1'b1;
    toggles = 0;
    last_up = user_paused;
    repeat (100) begin
      tick("hold");
      if (user_paused !== last_up) toggles++;
      last_up = user_paused;
    end
    check_val("hold_one_toggle", toggles, 1);
    check_val("hold_dim", dim_video, DIM_ON);
    user_pause = 1'b0;
    tick("hold_release");
    user_pause = 1'b1;
    tick("second_press");
    check_val("second_up", user_paused, 0);
    check_val("second_pause", pause, 0);
    check_val("second_dim", dim_video, 0);
    user_pause = 1'b0;
    tick("dim_clear");

    // OSD pause only with enable; never ages the dim counter.
    osd_open = 1'b1;
    tick("osd_noen");
    check_val("osd_noen_pause", pause, 0);
    osd_pause_en = 1'b1;
    tick("osd_en");
    check_val("osd_en_pause", pause, 1);
    repeat (20) tick("osd_hold");
    check_val("osd_dim", dim_video, 0);
    osd_open = 1'b0; osd_pause_en = 1'b0;
    tick("osd_end");

    // Button held across reset must be released before it counts.
    user_pause = 1'b1;
    apply_reset();
    repeat (5) tick("held_reset");
    check_val("held_no_toggle", user_paused, 0);
    user_pause = 1'b0;
    tick("held_low");
    user_pause = 1'b1;
    tick("held_press");
    check_val("held_toggle", user_paused, 1);
    user_pause = 1'b0;
    tick("held_low2");
    user_pause = 1'b1;
    tick("held_press2");
    user_pause = 1'b0;
    tick("held_low3");

    // Reset in GRANT drops grant and pause without a clock edge.
    hs_req = 1'b1;
    repeat (6) tick("rst_grant");
    check_val("rst_pre_grant", hs_grant, 1);
    #3;
    reset = 1'b1;
    #1;
    check_val("rst_async_grant", hs_grant, 0);
    check_val("rst_async_pause", pause, 0);
    model_reset();
    hs_req = 1'b0;
    @(negedge clk_sys);
    reset = 1'b0;
    tick("rst_after");

    // Long user pause.
    user_pause = 1'b1;
    tick("long_press");
    user_pause = 1'b0;
    repeat (1000) tick("long_hold");
    check_val("long_dim", dim_video, DIM_ON);
    user_pause = 1'b1;
    tick("long_unpress");
    user_pause = 1'b0;
    tick("long_end");

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(11) == 0) hs_req = ~hs_req;
      if ($urandom_range(9) == 0) user_pause = ~user_pause;
      if ($urandom_range(15) == 0) osd_open = ~osd_open;
      if ($urandom_range(15) == 0) osd_pause_en = ~osd_pause_en;
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pause_arbiter.md
PAUSE_ARBITER -- requirements
Module: pause_arbiter

Interface
REQ-001 The block SHALL have parameter DIM_CYCLES, default 32'h0ABA9500, giving the number of user-pause cycles before dimming.
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 4 (range 1..15), giving the cycles between pause assertion and high-score grant.
REQ-003 The block SHALL have port clk_sys, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port user_pause, input, 1 bit: the level of the pause button.
REQ-006 The block SHALL have port osd_open, input, 1 bit: the OSD is visible.
REQ-007 The block SHALL have port osd_pause_en, input, 1 bit: pausing while the OSD is open is enabled.
REQ-008 The block SHALL have port hs_req, input, 1 bit: a level request from the high-score engine for RAM access.
REQ-009 The block SHALL have port hs_grant, output, 1 bit: the high-score engine may access game RAM.
REQ-010 The block SHALL have port pause, output, 1 bit: halts the game core.
REQ-011 The block SHALL have port user_paused, output, 1 bit: the user toggle state.
REQ-012 The block SHALL have port dim_video, output, 1 bit: requests half-intensity RGB.

Function
REQ-013 The block SHALL toggle user_paused on each rising edge of user_pause, detected against a registered copy; a held level SHALL NOT retoggle.
REQ-014 The block SHALL register pause as: user_paused OR (osd_open AND osd_pause_en) OR (arbiter state != IDLE).
REQ-015 The arbiter SHALL implement states IDLE, HALT, GRANT and RELEASE.
REQ-016 IDLE: when hs_req=1, the arbiter SHALL go to HALT and load the settle counter with SETTLE_CYCLES.
REQ-017 HALT: the settle counter SHALL decrement each cycle; at 0 the arbiter SHALL go to GRANT; if hs_req=0, it SHALL go to IDLE with no grant.
REQ-018 GRANT: hs_grant SHALL be 1; when hs_req=0, the arbiter SHALL go to RELEASE.
REQ-019 RELEASE: hs_grant SHALL be 0 for one cycle and pause SHALL stay 1 for that cycle, then the arbiter SHALL go to IDLE.
REQ-020 hs_grant SHALL rise no earlier than SETTLE_CYCLES+1 cycles after pause rises because of hs_req.
REQ-021 hs_grant SHALL never be 1 while pause is 0.
REQ-022 hs_req re-asserted in RELEASE SHALL be serviced only after the return to IDLE.
REQ-023 A user toggle or OSD change during HALT or GRANT SHALL update user_paused but SHALL NOT drop pause or hs_grant.
REQ-024 While user_paused=1, the 32-bit dim counter SHALL increment each cycle, saturating at DIM_CYCLES.
REQ-025 dim_video SHALL be 1 when the dim counter >= DIM_CYCLES.
REQ-026 When user_paused=0, the dim counter SHALL clear to 0 on the next cycle, and dim_video SHALL fall in that same cycle.
REQ-027 OSD-only pause and high-score pause SHALL NOT advance the dim counter.

Reset
REQ-028 On reset assertion, the block SHALL asynchronously force: state=IDLE, hs_grant=0, pause=0, user_paused=0, dim_video=0, dim counter=0, settle counter=0, edge register=0.
REQ-029 Reset mid-GRANT SHALL drop hs_grant immediately, with no RELEASE cycle.
REQ-030 After reset deasserts, a user_pause level already high SHALL NOT toggle until it is seen low and then high.

Configuration
REQ-031 With macro PAUSE_ARBITER_DIM_EN defined, the block SHALL compile in the dim counter and dim_video SHALL behave per REQ-024..027.
REQ-032 Without PAUSE_ARBITER_DIM_EN, the block SHALL contain no dim counter and dim_video SHALL be constant 0.

Verification
REQ-033 Verification SHALL cover: hs_req=1 from IDLE with SETTLE_CYCLES=4 -> pause=1 at cycle 1, hs_grant=1 at cycle 6; hs_req=0 -> hs_grant=0 next cycle, pause=0 one cycle later.
REQ-034 Verification SHALL cover: hs_req pulsed for 2 cycles (dropped in HALT) -> hs_grant stays 0 and pause returns to 0 within 2 cycles.
REQ-035 Verification SHALL cover: user_pause held high for 100 cycles -> exactly one toggle; a second press -> user_paused=0 and pause=0.
REQ-036 Verification SHALL cover: DIM_CYCLES=16 with user pause on -> dim_video=1 at counter 16 and held; unpause -> dim_video=0 next cycle, counter=0.
REQ-037 Verification SHALL cover: osd_open=1 with osd_pause_en=0 -> pause=0; osd_pause_en=1 -> pause=1 and dim counter stays 0.
REQ-038 Verification SHALL cover: reset asserted in GRANT -> hs_grant=0 and pause=0 without waiting for a clock edge; build without PAUSE_ARBITER_DIM_EN -> dim_video=0 after 1000 paused cycles.
